branch_compare_unit: RTL and testbench

BRANCH_COMPARE_UNIT -- requirements
Module: branch_compare_unit

---
 rtl/branch_compare_unit.sv | 114 +++++++++++
 tb/tb_branch_compare_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_unit.sv
// Single-stage branch compare: evaluates the condition, mispredict flag and PC+Imm target, with a valid/ready output register.
// Optional statistics counters are enabled by defining BRANCH_COMPARE_STATS_EN.
module branch_compare_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Com_Src1,
    input  logic [WIDTH-1:0] Com_Src2,
    input  logic [2:0]       ComControl,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Imm,
    input  logic             PredTaken,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             ComResult,
    output logic             Mispredict,
    output logic [WIDTH-1:0] Target
`ifdef BRANCH_COMPARE_STATS_EN
    ,
    input  logic              Stats_Clr,
    output logic [STAT_W-1:0] BrCount,
    output logic [STAT_W-1:0] MissCount
`endif
);

    logic             r_out_valid;
    logic             r_com_result;
    logic             r_mispredict;
    logic [WIDTH-1:0] r_target;

    logic             w_accept;
    logic             w_out_fire;
    logic             w_taken;
    logic [WIDTH-1:0] w_target;

    // Flush blocks acceptance and suppresses the output handshake in the same cycle
    assign In_Ready   = (~r_out_valid | Out_Ready) & ~Flush;
    assign w_accept   = In_Valid & In_Ready;
    assign w_out_fire = r_out_valid & Out_Ready & ~Flush;
    assign w_target   = WIDTH'(PC + Imm);

    always_comb begin
        w_taken = 1'b0;
        case (ComControl)
            3'd0: w_taken = (Com_Src1 == Com_Src2);
            3'd1: w_taken = (Com_Src1 != Com_Src2);
            3'd2: w_taken = 1'b1;
            3'd3: w_taken = 1'b1;
            3'd4: w_taken = ($signed(Com_Src1) <  $signed(Com_Src2));
            3'd5: w_taken = ($signed(Com_Src1) >= $signed(Com_Src2));
            3'd6: w_taken = (Com_Src1 <  Com_Src2);
            3'd7: w_taken = (Com_Src1 >= Com_Src2);
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid  <= 1'b0;
            r_com_result <= 1'b0;
            r_mispredict <= 1'b0;
            r_target     <= '0;
        end else if (Flush) begin
            r_out_valid  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_com_result <= w_taken;
            r_mispredict <= w_taken ^ PredTaken;
            r_target     <= w_target;
        end else if (w_out_fire) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign Out_Valid  = r_out_valid;
    assign ComResult  = r_com_result;
    assign Mispredict = r_mispredict;
    assign Target     = r_target;

`ifdef BRANCH_COMPARE_STATS_EN
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_miss_count;

    // Saturating counters of consumed results; clear wins over increment
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else if (Stats_Clr) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else if (w_out_fire) begin
            if (r_br_count != '1) begin
                r_br_count <= r_br_count + STAT_W'(1);
            end
            if (r_mispredict && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + STAT_W'(1);
            end
        end
    end

    assign BrCount   = r_br_count;
    assign MissCount = r_miss_count;
`else
    if (STAT_W == 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_branch_compare_unit.sv
// Bench for branch_compare_unit: directed table, hand-written handshake/flush/reset sequences and random traffic
// checked against a queue-based scoreboard.
module tb_branch_compare_unit;

    localparam int unsigned W = 32;

    logic         CLK;
    logic         Reset_n;
    logic         In_Valid;
    logic         In_Ready;
    logic [W-1:0] Com_Src1;
    logic [W-1:0] Com_Src2;
    logic [2:0]   ComControl;
    logic [W-1:0] PC;
    logic [W-1:0] Imm;
    logic         PredTaken;
    logic         Flush;
    logic         Out_Valid;
    logic         Out_Ready;
    logic         ComResult;
    logic         Mispredict;
    logic [W-1:0] Target;
    logic         Stats_Clr;
`ifdef BRANCH_COMPARE_STATS_EN
    logic [31:0]  BrCount;
    logic [31:0]  MissCount;
`endif

    branch_compare_unit #(.WIDTH(W), .STAT_W(32)) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Com_Src1   (Com_Src1),
        .Com_Src2   (Com_Src2),
        .ComControl (ComControl),
        .PC         (PC),
        .Imm        (Imm),
        .PredTaken  (PredTaken),
        .Flush      (Flush),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .ComResult  (ComResult),
        .Mispredict (Mispredict),
        .Target     (Target)
`ifdef BRANCH_COMPARE_STATS_EN
        ,
        .Stats_Clr  (Stats_Clr),
        .BrCount    (BrCount),
        .MissCount  (MissCount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic         res;
        logic         mis;
        logic [W-1:0] tgt;
    } res_t;

    typedef struct {
        logic [2:0]   ctl;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic         pred;
        logic [W-1:0] pc;
        logic [W-1:0] imm;
        logic         exp_res;
        logic         exp_mis;
        logic [W-1:0] exp_tgt;
    } vec_t;

    res_t        q[$];
    logic [31:0] m_br;
    logic [31:0] m_miss;
    int          n_vec;
    int          n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint to_signed(input logic [W-1:0] a);
        return a[W-1] ? (longint'(a) - (longint'(1) << W)) : longint'(a);
    endfunction

    // Branch condition straight from the opcode table
    function automatic logic ref_taken(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (c)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return to_signed(a) <  to_signed(b);
            3'd5: return to_signed(a) >= to_signed(b);
            3'd6: return ua <  ub;
            3'd7: return ua >= ub;
            default: return 1'b1;
        endcase
    endfunction

    // One clock: drive at negedge, check outputs, then advance the scoreboard at posedge
    task automatic cycle(input logic v, input logic [W-1:0] s1, input logic [W-1:0] s2, input logic [2:0] c,
                         input logic [W-1:0] pc, input logic [W-1:0] imm, input logic pred,
                         input logic flush, input logic ordy, input logic clr);
        logic exp_vld, exp_rdy, accept, fire;
        res_t r;
        @(negedge CLK);
        In_Valid = v; Com_Src1 = s1; Com_Src2 = s2; ComControl = c; PC = pc; Imm = imm;
        PredTaken = pred; Flush = flush; Out_Ready = ordy; Stats_Clr = clr;
        #1;
        exp_vld = (q.size() != 0);
        exp_rdy = (!exp_vld || ordy) && !flush;
        check("in_ready", 64'(In_Ready), 64'(exp_rdy));
        check("out_valid", 64'(Out_Valid), 64'(exp_vld));
        if (exp_vld) begin
            check("com_result", 64'(ComResult), 64'(q[0].res));
            check("mispredict", 64'(Mispredict), 64'(q[0].mis));
            check("target", 64'(Target), 64'(q[0].tgt));
        end
`ifdef BRANCH_COMPARE_STATS_EN
        check("br_count", 64'(BrCount), 64'(m_br));
        check("miss_count", 64'(MissCount), 64'(m_miss));
`endif
        accept = v && exp_rdy;
        fire   = exp_vld && ordy && !flush;
        r.res  = ref_taken(c, s1, s2);
        r.mis  = r.res != pred;
        r.tgt  = W'(longint'(pc) + longint'(imm));
        @(posedge CLK);
        if (clr) begin
            m_br = 0; m_miss = 0;
        end else if (fire) begin
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (q[0].mis && m_miss != 32'hFFFF_FFFF) m_miss++;
        end
        if (flush) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (accept) q.push_back(r);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 3'd0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    vec_t        tab[$];
    vec_t        t;
    logic [31:0] br_before;
    logic [31:0] rs1, rs2;

    initial begin
        n_vec = 0; n_err = 0; m_br = 0; m_miss = 0;
        In_Valid = 0; Com_Src1 = 0; Com_Src2 = 0; ComControl = 0; PC = 0; Imm = 0;
        PredTaken = 0; Flush = 0; Out_Ready = 0; Stats_Clr = 0;
        Reset_n = 0;
        #1;
        check("rst_out_valid", 64'(Out_Valid), 64'd0);
        check("rst_com_result", 64'(ComResult), 64'd0);
        check("rst_mispredict", 64'(Mispredict), 64'd0);
        check("rst_target", 64'(Target), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        Reset_n = 1;

        // ctl, s1, s2, pred, pc, imm, exp_res, exp_mis, exp_tgt
        tab.push_back('{3'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1000, 32'h10, 1'b1, 1'b1, 32'h1010});
        tab.push_back('{3'd6, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1000, 32'h10, 1'b0, 1'b0, 32'h1010});
        tab.push_back('{3'd5, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h1000, 32'h10, 1'b0, 1'b1, 32'h1010});
        tab.push_back('{3'd7, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h1000, 32'h10, 1'b1, 1'b0, 32'h1010});
        tab.push_back('{3'd2, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, 32'h10});
        tab.push_back('{3'd3, 32'h5, 32'h9, 1'b1, 32'h8000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h7FFF_FFFC});
        tab.push_back('{3'd0, 32'h5, 32'h5, 1'b0, 32'h0, 32'h4, 1'b1, 1'b1, 32'h4});
        tab.push_back('{3'd0, 32'h5, 32'h6, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 32'h4});
        tab.push_back('{3'd1, 32'h5, 32'h5, 1'b1, 32'h0, 32'h4, 1'b0, 1'b1, 32'h4});
        tab.push_back('{3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0});
        tab.push_back('{3'd6, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0});
        tab.push_back('{3'd7, 32'h7, 32'h7, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0});

        for (int i = 0; i < tab.size(); i++) begin
            t = tab[i];
            cycle(1'b1, t.s1, t.s2, t.ctl, t.pc, t.imm, t.pred, 1'b0, 1'b1, 1'b0);
            #1;
            check("tab_valid", 64'(Out_Valid), 64'd1);
            check("tab_res", 64'(ComResult), 64'(t.exp_res));
            check("tab_mis", 64'(Mispredict), 64'(t.exp_mis));
            check("tab_tgt", 64'(Target), 64'(t.exp_tgt));
        end
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: hold for three cycles, then release with a same-cycle accept
        cycle(1'b1, 32'h3, 32'h4, 3'd6, 32'h100, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h9, 32'h9, 3'd1, 32'h200, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h9, 32'h9, 3'd0, 32'h300, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("bp_reload_tgt", 64'(Target), 64'h308);
        idle(1'b1);
        idle(1'b1);

        // Streaming: eight back-to-back requests
        br_before = m_br;
        for (int i = 0; i < 8; i++)
            cycle(1'b1, $urandom, $urandom, 3'($urandom), $urandom, $urandom, 1'($urandom), 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("stream_count", 64'(m_br - br_before), 64'd8);

        // Flush a stalled result; it must not be counted
        cycle(1'b1, 32'h1, 32'h2, 3'd4, 32'h40, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h1, 32'h2, 3'd4, 32'h50, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset while stalled clears everything without a clock edge
        cycle(1'b1, 32'h6, 32'h6, 3'd0, 32'hABC0, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge CLK);
        #2;
        Reset_n = 0;
        #1;
        check("rst_mid_valid", 64'(Out_Valid), 64'd0);
        check("rst_mid_res", 64'(ComResult), 64'd0);
        check("rst_mid_mis", 64'(Mispredict), 64'd0);
        check("rst_mid_tgt", 64'(Target), 64'd0);
`ifdef BRANCH_COMPARE_STATS_EN
        check("rst_mid_br", 64'(BrCount), 64'd0);
        check("rst_mid_miss", 64'(MissCount), 64'd0);
`endif
        q.delete();
        m_br = 0; m_miss = 0;
        @(negedge CLK);
        Reset_n = 1;
        cycle(1'b1, 32'h2, 32'h1, 3'd7, 32'h10, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 32'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), rs1, rs2, 3'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
